// File: rtl/traffic_pkg.sv
// Shared light-pattern constants, phase encodings and sequencing helpers
// used by the traffic controller and its sequence checker.
package traffic_pkg;

  // Patterns are {red, amber, green}
  localparam logic [2:0] RED       = 3'b100;
  localparam logic [2:0] RED_AMBER = 3'b110;
  localparam logic [2:0] GREEN     = 3'b001;
  localparam logic [2:0] AMBER     = 3'b010;

  typedef enum logic [1:0] {
    PH_RED       = 2'd0,
    PH_RED_AMBER = 2'd1,
    PH_GREEN     = 2'd2,
    PH_AMBER     = 2'd3
  } phase_t;

  function automatic phase_t next_phase(input phase_t ph);
    case (ph)
      PH_RED:       next_phase = PH_RED_AMBER;
      PH_RED_AMBER: next_phase = PH_GREEN;
      PH_GREEN:     next_phase = PH_AMBER;
      default:      next_phase = PH_RED;
    endcase
  endfunction

  function automatic logic [2:0] phase_pattern(input phase_t ph);
    case (ph)
      PH_RED:       phase_pattern = RED;
      PH_RED_AMBER: phase_pattern = RED_AMBER;
      PH_GREEN:     phase_pattern = GREEN;
      default:      phase_pattern = AMBER;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
// 1-cycle latency from inc/clr to cnt.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_seq_checker.sv
// Passive monitor of red/amber/green lamps: tracks the legal light sequence,
// counts cycles and errors, flags over-long phases. All outputs 1 cycle after P.
module traffic_seq_checker
  import traffic_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16,
  parameter int DWELL_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             red,
  input  logic             amber,
  input  logic             green,
  input  logic             clr,
  output logic             in_sync,
  output logic [1:0]       phase,
  output logic             seq_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             stuck
);

  // Low two bits of a tracked state are its phase encoding; bit 2 marks UNSYNC.
  typedef enum logic [2:0] {
    ST_RED       = 3'b000,
    ST_RED_AMBER = 3'b001,
    ST_GREEN     = 3'b010,
    ST_AMBER     = 3'b011,
    ST_UNSYNC    = 3'b100
  } state_t;

  localparam logic [DWELL_W-1:0] DWELL_MAX = '1;
  localparam logic [DWELL_W-1:0] STUCK_AT  = DWELL_W'(TIMEOUT - 1);

  logic [2:0]         pat;
  state_t             state, state_nx;
  logic [DWELL_W-1:0] dwell, dwell_nx;
  logic               err_nx;
  logic               cyc_inc;
  phase_t             cur_ph;
  phase_t             nxt_ph;

  assign pat = {red, amber, green};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_UNSYNC;
      dwell   <= '0;
      seq_err <= 1'b0;
    end else begin
      state   <= state_nx;
      dwell   <= dwell_nx;
      seq_err <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    dwell_nx = dwell;
    err_nx   = 1'b0;
    cyc_inc  = 1'b0;
    cur_ph   = phase_t'(state[1:0]);
    nxt_ph   = next_phase(cur_ph);
    if (state == ST_UNSYNC) begin
      dwell_nx = '0;
      if (pat == RED) begin
        state_nx = ST_RED;
      end
    end else if (pat == phase_pattern(cur_ph)) begin
      if (dwell != DWELL_MAX) begin
        dwell_nx = dwell + 1'b1;
      end
    end else if (pat == phase_pattern(nxt_ph)) begin
      state_nx = state_t'({1'b0, nxt_ph});
      dwell_nx = '0;
      cyc_inc  = (cur_ph == PH_AMBER);
    end else begin
      // A red lamp after an error resyncs immediately rather than via UNSYNC.
      err_nx   = 1'b1;
      dwell_nx = '0;
      state_nx = (pat == RED) ? ST_RED : ST_UNSYNC;
    end
  end

  assign in_sync = (state != ST_UNSYNC);
  assign phase   = in_sync ? state[1:0] : 2'd0;
  assign stuck   = in_sync && (dwell >= STUCK_AT);

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (err_nx),
    .cnt (err_cnt)
  );

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (cyc_inc),
    .cnt (cycle_cnt)
  );

endmodule

// File: tb/tb_traffic_seq_checker.sv
// Bench for traffic_seq_checker: vector table plus directed stuck/saturation runs,
// expected outputs queued at drive time and checked one edge later.
module tb_traffic_seq_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       red = 1'b0, amber = 1'b0, green = 1'b0;
  logic       clr = 1'b0;
  logic       in_sync;
  logic [1:0] phase;
  logic       seq_err;
  logic [7:0] err_cnt;
  logic [7:0] cycle_cnt;
  logic       stuck;

  int total = 0;
  int bad   = 0;
  int row   = 0;

  always #5 clk = ~clk;

  traffic_seq_checker #(.CNT_W(8), .TIMEOUT(16), .DWELL_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .red       (red),
    .amber     (amber),
    .green     (green),
    .clr       (clr),
    .in_sync   (in_sync),
    .phase     (phase),
    .seq_err   (seq_err),
    .err_cnt   (err_cnt),
    .cycle_cnt (cycle_cnt),
    .stuck     (stuck)
  );

  typedef struct {
    logic       rst;
    logic       clr;
    logic [2:0] p;
    logic       sync;
    logic [1:0] ph;
    logic       err;
    logic [7:0] ecnt;
    logic [7:0] ccnt;
    logic       stk;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[24];

  function automatic vec_t mk(input logic r, input logic c, input logic [2:0] p,
                              input logic s, input logic [1:0] ph, input logic e,
                              input logic [7:0] ec, input logic [7:0] cc, input logic st);
    vec_t v;
    v.rst = r; v.clr = c; v.p = p; v.sync = s; v.ph = ph;
    v.err = e; v.ecnt = ec; v.ccnt = cc; v.stk = st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d got %0h want %0h", nm, row, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst = v.rst;
    clr = v.clr;
    {red, amber, green} = v.p;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("in_sync",   {7'd0, in_sync}, {7'd0, e.sync});
    chk("phase",     {6'd0, phase},   {6'd0, e.ph});
    chk("seq_err",   {7'd0, seq_err}, {7'd0, e.err});
    chk("err_cnt",   err_cnt,         e.ecnt);
    chk("cycle_cnt", cycle_cnt,       e.ccnt);
    chk("stuck",     {7'd0, stuck},   {7'd0, e.stk});
    row++;
  endtask

  initial begin
    //            rst clr  P       sync ph err ecnt ccnt stk
    tbl[0]  = mk(1, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 3'b100, 1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 3'b110, 1, 1, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 3'b001, 1, 2, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 3'b010, 1, 3, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 3'b100, 1, 0, 0, 0, 1, 0);
    tbl[6]  = mk(0, 0, 3'b110, 1, 1, 0, 0, 1, 0);
    tbl[7]  = mk(0, 0, 3'b001, 1, 2, 0, 0, 1, 0);
    tbl[8]  = mk(0, 0, 3'b100, 1, 0, 1, 1, 1, 0);  // GREEN -> RED skip, resync
    tbl[9]  = mk(0, 0, 3'b100, 1, 0, 0, 1, 1, 0);
    tbl[10] = mk(0, 0, 3'b111, 0, 0, 1, 2, 1, 0);  // illegal pattern drops sync
    tbl[11] = mk(0, 0, 3'b010, 0, 0, 0, 2, 1, 0);
    tbl[12] = mk(0, 0, 3'b010, 0, 0, 0, 2, 1, 0);
    tbl[13] = mk(0, 0, 3'b010, 0, 0, 0, 2, 1, 0);
    tbl[14] = mk(0, 0, 3'b100, 1, 0, 0, 2, 1, 0);
    tbl[15] = mk(0, 1, 3'b110, 1, 1, 0, 0, 0, 0);
    tbl[16] = mk(0, 0, 3'b010, 0, 0, 1, 1, 0, 0);  // RED_AMBER -> AMBER skip
    tbl[17] = mk(0, 0, 3'b100, 1, 0, 0, 1, 0, 0);
    tbl[18] = mk(0, 0, 3'b110, 1, 1, 0, 1, 0, 0);
    tbl[19] = mk(1, 0, 3'b110, 0, 0, 0, 0, 0, 0);  // reset mid RED_AMBER
    tbl[20] = mk(0, 0, 3'b110, 0, 0, 0, 0, 0, 0);
    tbl[21] = mk(0, 0, 3'b001, 0, 0, 0, 0, 0, 0);
    tbl[22] = mk(0, 0, 3'b100, 1, 0, 0, 0, 0, 0);
    tbl[23] = mk(0, 1, 3'b011, 0, 0, 1, 0, 0, 0);  // clr beats err increment

    for (int i = 0; i < 24; i++) apply(tbl[i]);

    // Stuck: hold GREEN for 20 clocks, asserting on the 16th
    apply(mk(1, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    apply(mk(0, 0, 3'b100, 1, 0, 0, 0, 0, 0));
    apply(mk(0, 0, 3'b110, 1, 1, 0, 0, 0, 0));
    for (int k = 1; k <= 20; k++)
      apply(mk(0, 0, 3'b001, 1, 2, 0, 0, 0, (k >= 16)));
    apply(mk(0, 0, 3'b010, 1, 3, 0, 0, 0, 0));
    // Error also clears stuck: hold AMBER into stuck, then jump to GREEN
    for (int k = 2; k <= 17; k++)
      apply(mk(0, 0, 3'b010, 1, 3, 0, 0, 0, (k >= 16)));
    apply(mk(0, 0, 3'b001, 0, 0, 1, 1, 0, 0));

    // cycle_cnt saturation over 300 legal light cycles
    apply(mk(1, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    apply(mk(0, 0, 3'b100, 1, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 300; k++) begin
      logic [7:0] prev;
      logic [7:0] now;
      prev = (k - 1 > 255) ? 8'd255 : 8'(k - 1);
      now  = (k > 255) ? 8'd255 : 8'(k);
      apply(mk(0, 0, 3'b110, 1, 1, 0, 0, prev, 0));
      apply(mk(0, 0, 3'b001, 1, 2, 0, 0, prev, 0));
      apply(mk(0, 0, 3'b010, 1, 3, 0, 0, prev, 0));
      apply(mk(0, 0, 3'b100, 1, 0, 0, 0, now, 0));
    end
    apply(mk(0, 0, 3'b110, 1, 1, 0, 0, 255, 0));
    apply(mk(0, 0, 3'b001, 1, 2, 0, 0, 255, 0));
    apply(mk(0, 0, 3'b010, 1, 3, 0, 0, 255, 0));
    apply(mk(0, 1, 3'b100, 1, 0, 0, 0, 0, 0));   // clr coincident with AMBER->RED
    apply(mk(0, 0, 3'b110, 1, 1, 0, 0, 0, 0));
    apply(mk(0, 0, 3'b001, 1, 2, 0, 0, 0, 0));
    apply(mk(0, 0, 3'b010, 1, 3, 0, 0, 0, 0));
    apply(mk(0, 0, 3'b100, 1, 0, 0, 0, 1, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
